calc_mem_arbiter: RTL and testbench

Shares the calculator's single 16-bit memory port between two requesters: the calculator controller (port A) and the display/history scanner (port B). Arbitration is round-robin with a req/gnt handshake. Each granted request issues exactly one memory access (read or write). Read data returns on a per-port rvalid strobe. The block sits between both requesters and the memory's oe/we/mem_addr/mem_data_in/mem_data_out pins.

---
 rtl/calc_mem_arbiter_pkg.sv | 25 ++
 rtl/calc_mem_arbiter_if.sv | 48 ++++
 rtl/calc_mem_arbiter_rr_arb2.sv | 23 ++
 rtl/calc_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_calc_mem_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_mem_arbiter_pkg.sv
// Shared types and default widths for the calculator memory-port arbiter.
package calc_mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/calc_mem_arbiter_if.sv
// Requester A/B handshakes plus the memory pins; slave = arbiter side.
interface calc_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              gnt_a;
  logic              rvalid_a;
  logic [DATA_W-1:0] rdata_a;

  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_b;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata_b;

  logic              oe;
  logic              we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              busy;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  mem_data_out,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b,
    output oe, we, mem_addr, mem_data_in, busy
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output mem_data_out,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b,
    input  oe, we, mem_addr, mem_data_in, busy
  );

endinterface

// File: rtl/calc_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; the pointer register lives in the parent.
module rr_arb2
  import calc_mem_pkg::*;
(
  input  logic    i_req_a,
  input  logic    i_req_b,
  input  req_id_t i_ptr,
  output logic    o_valid_c,
  output req_id_t o_winner_c
);

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    o_valid_c  = i_req_a | i_req_b;
    o_winner_c = REQ_A;
    if (i_req_a && i_req_b) begin
      o_winner_c = i_ptr;
    end else if (i_req_b) begin
      o_winner_c = REQ_B;
    end
  end

endmodule

// File: rtl/calc_mem_arbiter.sv
// Round-robin sharing of the single memory port between the controller (A)
// and the display/history scanner (B); one access in flight at a time.
module calc_mem_arbiter #(
  parameter int unsigned ADDR_W   = calc_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W   = calc_mem_pkg::DATA_W,
  parameter int unsigned READ_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  calc_mem_arbiter_if.slave  bus
);
  import calc_mem_pkg::*;

  localparam int unsigned CNT_W = 2;

  arb_state_t        r_state;
  req_id_t           r_ptr;
  req_id_t           r_winner;
  logic              r_is_wr;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_gnt_a;
  logic              r_gnt_b;
  logic              r_rvalid_a;
  logic              r_rvalid_b;
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;
  logic              r_oe;
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data_in;
  logic              r_busy;

  logic              w_valid;
  req_id_t           w_winner;
  mem_req_t          w_sel;

  rr_arb2 u_rr_arb2 (
    .i_req_a    (bus.req_a),
    .i_req_b    (bus.req_b),
    .i_ptr      (r_ptr),
    .o_valid_c  (w_valid),
    .o_winner_c (w_winner)
  );

  assign w_sel = (w_winner == REQ_B) ? {bus.we_b, bus.addr_b, bus.wdata_b}
                                     : {bus.we_a, bus.addr_a, bus.wdata_a};

  // Memory pins and gnt are loaded on the IDLE->ISSUE edge so they are valid
  // exactly during the ISSUE cycle; the output registers hold the latched request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ptr         <= REQ_A;
      r_winner      <= REQ_A;
      r_is_wr       <= 1'b0;
      r_cnt         <= '0;
      r_gnt_a       <= 1'b0;
      r_gnt_b       <= 1'b0;
      r_rvalid_a    <= 1'b0;
      r_rvalid_b    <= 1'b0;
      r_rdata_a     <= '0;
      r_rdata_b     <= '0;
      r_oe          <= 1'b0;
      r_we          <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_gnt_a       <= 1'b0;
      r_gnt_b       <= 1'b0;
      r_rvalid_a    <= 1'b0;
      r_rvalid_b    <= 1'b0;
      r_oe          <= 1'b0;
      r_we          <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;

      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state       <= ISSUE;
            r_winner      <= w_winner;
            r_is_wr       <= w_sel.we;
            r_gnt_a       <= (w_winner == REQ_A);
            r_gnt_b       <= (w_winner == REQ_B);
            r_oe          <= ~w_sel.we;
            r_we          <= w_sel.we;
            r_mem_addr    <= w_sel.addr;
            r_mem_data_in <= w_sel.we ? w_sel.wdata : '0;
            r_busy        <= 1'b1;
          end else begin
            r_busy        <= 1'b0;
          end
        end

        ISSUE: begin
          r_ptr <= (r_winner == REQ_A) ? REQ_B : REQ_A;
          if (r_is_wr) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= WAIT_RD;
            r_cnt   <= CNT_W'(READ_LAT - 1);
            r_busy  <= 1'b1;
          end
        end

        WAIT_RD: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
            if (r_winner == REQ_A) begin
              r_rdata_a  <= bus.mem_data_out;
              r_rvalid_a <= 1'b1;
            end else begin
              r_rdata_b  <= bus.mem_data_out;
              r_rvalid_b <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_a       = r_gnt_a;
  assign bus.gnt_b       = r_gnt_b;
  assign bus.rvalid_a    = r_rvalid_a;
  assign bus.rvalid_b    = r_rvalid_b;
  assign bus.rdata_a     = r_rdata_a;
  assign bus.rdata_b     = r_rdata_b;
  assign bus.oe          = r_oe;
  assign bus.we          = r_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_data_in = r_mem_data_in;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_calc_mem_arbiter.sv
// Directed bench: READ_LAT=1 instance driven from a vector table, READ_LAT=3
// instance used for the reset-during-read sequence.
module tb_calc_mem_arbiter;

  localparam logic        T = 1'b1;
  localparam logic        F = 1'b0;
  localparam logic [15:0] Z = 16'h0000;

  typedef struct packed {
    logic        ra;
    logic        wa;
    logic [15:0] aa;
    logic [15:0] da;
    logic        rb;
    logic        wb;
    logic [15:0] ab;
    logic [15:0] db;
    logic [70:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] p1;
  logic [15:0] p3 [0:2];

  vec_t tbl [28];

  calc_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) if1 ();
  calc_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) if3 ();

  calc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (if1)
  );

  calc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) u_dut3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (if3)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears READ_LAT cycles after the oe cycle.
  always @(posedge clk) begin
    p1    <= if1.mem_addr;
    p3[0] <= if3.mem_addr;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign if1.mem_data_out = mem[p1];
  assign if3.mem_data_out = mem[p3[2]];

  logic [70:0] obs1;
  logic [70:0] obs3;
  assign obs1 = {if1.gnt_a, if1.gnt_b, if1.oe, if1.we, if1.rvalid_a, if1.rvalid_b, if1.busy,
                 if1.mem_addr, if1.mem_data_in, if1.rdata_a, if1.rdata_b};
  assign obs3 = {if3.gnt_a, if3.gnt_b, if3.oe, if3.we, if3.rvalid_a, if3.rvalid_b, if3.busy,
                 if3.mem_addr, if3.mem_data_in, if3.rdata_a, if3.rdata_b};

  function automatic logic [70:0] ev(input logic ga, input logic gb, input logic oe,
                                     input logic we, input logic rva, input logic rvb,
                                     input logic bz, input logic [15:0] ad,
                                     input logic [15:0] md, input logic [15:0] rda,
                                     input logic [15:0] rdb);
    return {ga, gb, oe, we, rva, rvb, bz, ad, md, rda, rdb};
  endfunction

  function automatic vec_t mk(input logic ra, input logic wa, input logic [15:0] aa,
                              input logic [15:0] da, input logic rb, input logic wb,
                              input logic [15:0] ab, input logic [15:0] db,
                              input logic [70:0] e);
    vec_t v;
    v.ra = ra; v.wa = wa; v.aa = aa; v.da = da;
    v.rb = rb; v.wb = wb; v.ab = ab; v.db = db;
    v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [70:0] act, input logic [70:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [70:0] zero;
    logic [70:0] idle1;
    vec_t        nul;
    vec_t        both;
    int          cyc;
    bit          seen;
    zero = '0;

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0020] = 16'h0007;
    mem[16'h0001] = 16'h1234;
    mem[16'h0002] = 16'h8000;

    {if1.req_a, if1.we_a, if1.addr_a, if1.wdata_a} = '0;
    {if1.req_b, if1.we_b, if1.addr_b, if1.wdata_b} = '0;
    {if3.req_a, if3.we_a, if3.addr_a, if3.wdata_a} = '0;
    {if3.req_b, if3.we_b, if3.addr_b, if3.wdata_b} = '0;
    rst1 = 1'b1;
    rst3 = 1'b1;

    step();
    step();
    chk("reset_dut1", obs1, zero);
    chk("reset_dut3", obs3, zero);
    rst1 = 1'b0;
    rst3 = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle1_%0d", i), obs1, zero);
      chk($sformatf("idle3_%0d", i), obs3, zero);
    end

    idle1 = ev(F, F, F, F, F, F, F, Z, Z, 16'h8000, 16'h0007);
    nul   = mk(F, F, Z, Z, F, F, Z, Z, zero);
    both  = mk(T, T, 16'h0030, 16'h0A0A, T, T, 16'h0040, 16'h0B0B, idle1);

    tbl[0]  = mk(T, T, 16'h0010, 16'hFFF6, F, F, Z, Z,
                 ev(T, F, F, T, F, F, T, 16'h0010, 16'hFFF6, Z, Z));
    tbl[1]  = mk(F, F, Z, Z, F, F, Z, Z, zero);
    tbl[2]  = mk(F, F, Z, Z, T, F, 16'h0020, Z,
                 ev(F, T, T, F, F, F, T, 16'h0020, Z, Z, Z));
    tbl[3]  = mk(F, F, Z, Z, F, F, Z, Z, ev(F, F, F, F, F, F, T, Z, Z, Z, Z));
    tbl[4]  = mk(F, F, Z, Z, F, F, Z, Z, ev(F, F, F, F, F, T, T, Z, Z, Z, 16'h0007));
    tbl[5]  = mk(F, F, Z, Z, F, F, Z, Z, ev(F, F, F, F, F, F, F, Z, Z, Z, 16'h0007));
    tbl[6]  = mk(T, F, 16'h0001, Z, F, F, Z, Z,
                 ev(T, F, T, F, F, F, T, 16'h0001, Z, Z, 16'h0007));
    tbl[7]  = mk(F, F, Z, Z, F, F, Z, Z, ev(F, F, F, F, F, F, T, Z, Z, Z, 16'h0007));
    tbl[8]  = mk(F, F, Z, Z, F, F, Z, Z,
                 ev(F, F, F, F, T, F, T, Z, Z, 16'h1234, 16'h0007));
    tbl[9]  = mk(T, F, 16'h0002, Z, F, F, Z, Z,
                 ev(F, F, F, F, F, F, F, Z, Z, 16'h1234, 16'h0007));
    tbl[10] = mk(T, F, 16'h0002, Z, F, F, Z, Z,
                 ev(T, F, T, F, F, F, T, 16'h0002, Z, 16'h1234, 16'h0007));
    tbl[11] = mk(F, F, Z, Z, F, F, Z, Z,
                 ev(F, F, F, F, F, F, T, Z, Z, 16'h1234, 16'h0007));
    tbl[12] = mk(F, F, Z, Z, F, F, Z, Z,
                 ev(F, F, F, F, T, F, T, Z, Z, 16'h8000, 16'h0007));
    tbl[13] = mk(F, F, Z, Z, F, F, Z, Z, idle1);
    tbl[14] = mk(F, F, Z, Z, T, T, 16'h0050, 16'h5555,
                 ev(F, T, F, T, F, F, T, 16'h0050, 16'h5555, 16'h8000, 16'h0007));
    tbl[15] = mk(F, F, Z, Z, F, F, Z, Z, idle1);
    for (int i = 16; i <= 22; i++) begin
      tbl[i] = both;
      if (i % 4 == 0)
        tbl[i].exp = ev(T, F, F, T, F, F, T, 16'h0030, 16'h0A0A, 16'h8000, 16'h0007);
      else if (i % 4 == 2)
        tbl[i].exp = ev(F, T, F, T, F, F, T, 16'h0040, 16'h0B0B, 16'h8000, 16'h0007);
    end
    tbl[23] = mk(F, F, Z, Z, F, F, Z, Z, idle1);
    tbl[24] = both;
    tbl[24].exp = ev(T, F, F, T, F, F, T, 16'h0030, 16'h0A0A, 16'h8000, 16'h0007);
    tbl[25] = mk(F, F, Z, Z, F, F, Z, Z, idle1);
    tbl[26] = mk(T, T, 16'h0030, 16'h0A0A, F, F, Z, Z,
                 ev(T, F, F, T, F, F, T, 16'h0030, 16'h0A0A, 16'h8000, 16'h0007));
    tbl[27] = mk(F, F, Z, Z, F, F, Z, Z, idle1);

    for (int i = 0; i < 28; i++) begin
      if1.req_a = tbl[i].ra; if1.we_a = tbl[i].wa; if1.addr_a = tbl[i].aa; if1.wdata_a = tbl[i].da;
      if1.req_b = tbl[i].rb; if1.we_b = tbl[i].wb; if1.addr_b = tbl[i].ab; if1.wdata_b = tbl[i].db;
      step();
      chk($sformatf("vec%0d", i), obs1, tbl[i].exp);
    end
    if1.req_a = nul.ra;
    if1.req_b = nul.rb;

    // Reset lands while the READ_LAT=3 instance sits in WAIT_RD.
    if3.req_b  = 1'b1;
    if3.we_b   = 1'b0;
    if3.addr_b = 16'h0020;
    step();
    chk("r3_issue", obs3, ev(F, T, T, F, F, F, T, 16'h0020, Z, Z, Z));
    if3.req_b = 1'b0;
    step();
    chk("r3_wait1", obs3, ev(F, F, F, F, F, F, T, Z, Z, Z, Z));
    step();
    chk("r3_wait2", obs3, ev(F, F, F, F, F, F, T, Z, Z, Z, Z));
    rst3 = 1'b1;
    step();
    chk("r3_reset", obs3, zero);
    rst3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("r3_quiet%0d", i), obs3, zero);
    end

    if3.req_b = 1'b1;
    step();
    chk("r3_regnt", obs3, ev(F, T, T, F, F, F, T, 16'h0020, Z, Z, Z));
    if3.req_b = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 12) begin
      step();
      cyc++;
      seen = if3.rvalid_b;
    end
    n_cmp++;
    if (cyc != 4) begin
      n_err++;
      $display("FAIL r3_latency: got %0d cycles want 4 (seen=%0d)", cyc, seen);
    end
    chk("r3_resp", obs3, ev(F, F, F, F, F, T, T, Z, Z, Z, 16'h0007));
    step();
    chk("r3_done", obs3, ev(F, F, F, F, F, F, F, Z, Z, Z, 16'h0007));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
